// File: rtl/rca_result_accumulator_pkg.sv
// Shared definitions for the result accumulator that sits behind the
// ripple-carry adder array.
//   - FSM state encoding (ACCUM collects beats, HOLD presents the total)
//   - default build widths and the derived beat-count limit
package rca_acc_defs;

  localparam logic ST_ACCUM = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam int unsigned DEF_IN_WIDTH  = 48;
  localparam int unsigned DEF_ACC_WIDTH = 56;
  localparam int unsigned DEF_CNT_WIDTH = 8;

  // A burst holds at most this many beats before it is force-closed.
  localparam int unsigned CNT_MAX = (2 ** DEF_CNT_WIDTH) - 1;

  typedef enum logic {
    StAccum = ST_ACCUM,
    StHold  = ST_HOLD
  } acc_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_result_accumulator_adder.sv
// Parameterised ripple-carry adder for the accumulate path, chained from
// full_adder cells with carry-in tied low.
//   a, b  : ACC_WIDTH-bit operands
//   sum   : ACC_WIDTH-bit result (modulo 2^ACC_WIDTH)
//   carry : carry-out of the top bit, feeds the overflow flag
module acc_ripple_adder #(
  parameter int unsigned ACC_WIDTH = 56
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry
);

  logic [ACC_WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign carry = c[ACC_WIDTH];

endmodule

// File: rtl/rca_result_accumulator.sv
// Streaming burst accumulator for adder results.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_valid/o_ready      : input beat handshake (i_data, i_last)
//   o_valid/i_ready      : burst-total handshake, held until accepted
//   o_sum                : burst total modulo 2^ACC_WIDTH
//   o_count              : beats in the burst
//   o_overflow           : accumulator carried out at least once in the burst
//   o_forced             : burst closed by the beat limit rather than i_last
module rca_result_accumulator
  import rca_acc_defs::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [IN_WIDTH-1:0]  i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_overflow,
  output logic                 o_forced
);

  // All-ones equals 2^CNT_WIDTH-1, the beat limit for this build.
  localparam logic [CNT_WIDTH-1:0] CntLimit = '1;

  acc_state_e state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 forced_q, forced_d;

  logic [ACC_WIDTH-1:0] data_ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 at_limit;

  assign data_ext = ACC_WIDTH'(i_data);
  assign cnt_inc  = cnt_q + 1'b1;
  assign at_limit = (cnt_inc == CntLimit);

  acc_ripple_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .a     (acc_q),
    .b     (data_ext),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    forced_d   = forced_q;

    unique case (state_q)
      StAccum: begin
        if (i_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_inc;
          if (i_last || at_limit) begin
            // Snapshot the total including the closing beat.
            state_d    = StHold;
            sum_d      = add_sum;
            count_d    = cnt_inc;
            overflow_d = ovf_q | add_carry;
            forced_d   = at_limit & ~i_last;
          end
        end
      end
      StHold: begin
        if (i_ready) begin
          state_d    = StAccum;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          sum_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          forced_d   = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      forced_q   <= forced_d;
    end
  end

  assign o_ready    = (state_q == StAccum);
  assign o_valid    = (state_q == StHold);
  assign o_sum      = sum_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_forced   = forced_q;

endmodule

// File: tb/tb_rca_result_accumulator.sv
module tb_rca_result_accumulator;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [47:0] i_data;
  logic        i_last;
  logic        i_ready;

  // Default 56-bit build
  logic        o_ready;
  logic        o_valid;
  logic [55:0] o_sum;
  logic [7:0]  o_count;
  logic        o_overflow;
  logic        o_forced;

  // 48-bit accumulator build, same stimulus
  logic        n_ready;
  logic        n_valid;
  logic [47:0] n_sum;
  logic [7:0]  n_count;
  logic        n_overflow;
  logic        n_forced;

  int total;
  int bad;

  logic [47:0] beats[$];

  rca_result_accumulator dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_forced   (o_forced)
  );

  rca_result_accumulator #(
    .IN_WIDTH  (48),
    .ACC_WIDTH (48),
    .CNT_WIDTH (8)
  ) dut48 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (n_ready),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_valid    (n_valid),
    .i_ready    (i_ready),
    .o_sum      (n_sum),
    .o_count    (n_count),
    .o_overflow (n_overflow),
    .o_forced   (n_forced)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_sum"}, 64'(o_sum), 64'd0);
    check({tag, "_count"}, 64'(o_count), 64'd0);
    check({tag, "_ovf"}, 64'(o_overflow), 64'd0);
    check({tag, "_forced"}, 64'(o_forced), 64'd0);
    check({tag, "_valid48"}, 64'(n_valid), 64'd0);
    check({tag, "_ready48"}, 64'(n_ready), 64'd1);
  endtask

  // Sends the queued beats as one burst. The expected total is the exact
  // integer sum; each build reports it modulo its own width and flags
  // overflow if the exact sum does not fit.
  task automatic run_burst(input bit use_last, input int hold_cycles);
    logic [63:0] exact;
    logic [7:0]  n_exp;
    int          n;
    bit          forced_exp;
    exact   = '0;
    n       = beats.size();
    n_exp   = 8'(n);
    i_ready = (hold_cycles == 0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        i_last  = 1'($urandom);
        i_data  = 48'($urandom);
        @(posedge i_clk);
        #1;
        check("idle_valid", 64'(o_valid), 64'd0);
      end
      i_valid = 1'b1;
      i_data  = beats[i];
      i_last  = use_last && (i == n - 1);
      check("accum_ready", 64'(o_ready), 64'd1);
      check("accum_ready48", 64'(n_ready), 64'd1);
      @(posedge i_clk);
      #1;
      exact += 64'(beats[i]);
      if (i != n - 1) check("early_valid", 64'(o_valid), 64'd0);
    end
    i_valid    = 1'b0;
    i_last     = 1'b0;
    forced_exp = !use_last;
    for (int h = 0; h <= hold_cycles; h++) begin
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
      check("hold_sum", 64'(o_sum), exact & 64'h00FF_FFFF_FFFF_FFFF);
      check("hold_count", 64'(o_count), 64'(n_exp));
      check("hold_ovf", 64'(o_overflow), 64'(exact[63:56] != 0));
      check("hold_forced", 64'(o_forced), 64'(forced_exp));
      check("hold_valid48", 64'(n_valid), 64'd1);
      check("hold_sum48", 64'(n_sum), exact & 64'h0000_FFFF_FFFF_FFFF);
      check("hold_count48", 64'(n_count), 64'(n_exp));
      check("hold_ovf48", 64'(n_overflow), 64'(exact[63:48] != 0));
      check("hold_forced48", 64'(n_forced), 64'(forced_exp));
      if (h < hold_cycles) begin
        // Beats offered during HOLD must be ignored.
        i_valid = 1'b1;
        i_data  = 48'($urandom);
        i_last  = 1'($urandom);
        @(posedge i_clk);
        #1;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("handoff_valid", 64'(o_valid), 64'd0);
    check("handoff_ready", 64'(o_ready), 64'd1);
    check("handoff_forced", 64'(o_forced), 64'd0);
    check("handoff_valid48", 64'(n_valid), 64'd0);
    beats.delete();
  endtask

  function automatic logic [47:0] rand_beat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: rand_beat = r[47:0];
      1: rand_beat = 48'hFFFF_FFFF_FFFF - 48'(r[3:0]);
      2: rand_beat = 48'h0;
      default: rand_beat = 48'(r[7:0]);
    endcase
  endfunction

  initial begin
    total   = 0;
    bad     = 0;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    beats.push_back(48'h1);
    beats.push_back(48'h2);
    beats.push_back(48'h3);
    run_burst(1'b1, 0);

    beats.push_back(48'hFFFF_FFFF_FFFF);
    run_burst(1'b1, 2);

    beats.push_back(48'hFFFF_FFFF_FFFF);
    beats.push_back(48'h2);
    run_burst(1'b1, 0);

    beats.push_back(48'h5);
    run_burst(1'b1, 0);

    for (int i = 0; i < 255; i++) beats.push_back(48'h1);
    run_burst(1'b0, 0);

    for (int i = 0; i < 255; i++) beats.push_back(48'h1);
    run_burst(1'b1, 0);

    beats.push_back(48'h0);
    beats.push_back(48'h0);
    run_burst(1'b1, 10);

    beats.push_back(48'h9);
    run_burst(1'b1, 0);

    // Reset in the middle of a four-beat burst.
    i_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_data  = 48'h11;
      i_last  = 1'b0;
      @(posedge i_clk);
      #1;
    end
    i_data = 48'h11;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    i_valid = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    beats.push_back(48'h7);
    run_burst(1'b1, 0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) beats.push_back(rand_beat());
      run_burst(1'b1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
